mem_arbiter: RTL and testbench

Shares one single-ported backing memory between the core's instruction-fetch port and its data (load/store) port. Each port uses a level request / single-cycle acknowledge handshake. The block sequences each access through a small FSM and gives data accesses priority. A starvation counter guarantees that fetch makes forward progress. It sits between `mipsCore`'s iCache/dCache interfaces and the external memory bus, and the fetch stage stalls on its `if_ack`.

---
 rtl/mem_arbiter_pkg.sv | 11 +
 rtl/mem_arbiter_arb_pick.sv | 23 ++
 rtl/mem_arbiter.sv | 149 ++++++++++++++
 tb/tb_mem_arbiter.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the instruction/data memory arbiter.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {ARB_IDLE, ARB_BUSY, ARB_RESP} arb_state_t;
  typedef enum logic {GNT_IF, GNT_D} arb_gnt_t;

  localparam int unsigned ARB_ADDR_W_DEF   = 32;
  localparam int unsigned ARB_DATA_W_DEF   = 32;
  localparam int unsigned ARB_MAX_DWIN_DEF = 4;

endpackage

// File: rtl/mem_arbiter_arb_pick.sv
// Combinational grant selection: data has priority until fetch has waited MAX_DWIN data grants.
module arb_pick
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned MAX_DWIN = ARB_MAX_DWIN_DEF,
  parameter int unsigned CNT_W    = $clog2(MAX_DWIN + 1)
) (
  input  logic             i_if_req,
  input  logic             i_d_req,
  input  logic [CNT_W-1:0] i_dwin_cnt,
  output logic             o_gnt_vld_c,
  output arb_gnt_t         o_gnt_port_c
);

  logic w_d_win;

  always_comb begin
    w_d_win      = i_d_req && (!i_if_req || (i_dwin_cnt < CNT_W'(MAX_DWIN)));
    o_gnt_vld_c  = w_d_win || i_if_req;
    o_gnt_port_c = w_d_win ? GNT_D : GNT_IF;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-ported memory between the fetch and data ports,
// one access at a time, with a fetch starvation guard.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W   = ARB_ADDR_W_DEF,
  parameter int unsigned DATA_W   = ARB_DATA_W_DEF,
  parameter int unsigned MAX_DWIN = ARB_MAX_DWIN_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_if_req,
  input  logic [ADDR_W-1:0] i_if_addr,
  output logic [DATA_W-1:0] o_if_rdata,
  output logic              o_if_ack,
  input  logic              i_d_req,
  input  logic              i_d_we,
  input  logic [ADDR_W-1:0] i_d_addr,
  input  logic [DATA_W-1:0] i_d_wdata,
  output logic [DATA_W-1:0] o_d_rdata,
  output logic              o_d_ack,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata,
  input  logic              i_mem_ready
);

  localparam int unsigned CNT_W = $clog2(MAX_DWIN + 1);

  arb_state_t        r_state,      w_nxt_state;
  arb_gnt_t          r_gnt,        w_nxt_gnt;
  logic [CNT_W-1:0]  r_dwin_cnt,   w_nxt_dwin_cnt;
  logic              r_mem_req,    w_nxt_mem_req;
  logic              r_mem_we,     w_nxt_mem_we;
  logic [ADDR_W-1:0] r_mem_addr,   w_nxt_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata,  w_nxt_mem_wdata;
  logic [DATA_W-1:0] r_if_rdata,   w_nxt_if_rdata;
  logic [DATA_W-1:0] r_d_rdata,    w_nxt_d_rdata;
  logic              r_if_ack,     w_nxt_if_ack;
  logic              r_d_ack,      w_nxt_d_ack;
  logic              w_gnt_vld;
  arb_gnt_t          w_gnt_port;

  arb_pick #(
    .MAX_DWIN (MAX_DWIN),
    .CNT_W    (CNT_W)
  ) u_pick (
    .i_if_req     (i_if_req),
    .i_d_req      (i_d_req),
    .i_dwin_cnt   (r_dwin_cnt),
    .o_gnt_vld_c  (w_gnt_vld),
    .o_gnt_port_c (w_gnt_port)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state     <= ARB_IDLE;
      r_gnt       <= GNT_IF;
      r_dwin_cnt  <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_if_rdata  <= '0;
      r_d_rdata   <= '0;
      r_if_ack    <= 1'b0;
      r_d_ack     <= 1'b0;
    end else begin
      r_state     <= w_nxt_state;
      r_gnt       <= w_nxt_gnt;
      r_dwin_cnt  <= w_nxt_dwin_cnt;
      r_mem_req   <= w_nxt_mem_req;
      r_mem_we    <= w_nxt_mem_we;
      r_mem_addr  <= w_nxt_mem_addr;
      r_mem_wdata <= w_nxt_mem_wdata;
      r_if_rdata  <= w_nxt_if_rdata;
      r_d_rdata   <= w_nxt_d_rdata;
      r_if_ack    <= w_nxt_if_ack;
      r_d_ack     <= w_nxt_d_ack;
    end
  end

  // Next-state and next-output logic; mem_* are latched only on a grant.
  always_comb begin
    w_nxt_state     = r_state;
    w_nxt_gnt       = r_gnt;
    w_nxt_dwin_cnt  = r_dwin_cnt;
    w_nxt_mem_req   = 1'b0;
    w_nxt_mem_we    = r_mem_we;
    w_nxt_mem_addr  = r_mem_addr;
    w_nxt_mem_wdata = r_mem_wdata;
    w_nxt_if_rdata  = r_if_rdata;
    w_nxt_d_rdata   = r_d_rdata;
    w_nxt_if_ack    = 1'b0;
    w_nxt_d_ack     = 1'b0;
    case (r_state)
      ARB_IDLE: begin
        if (w_gnt_vld) begin
          w_nxt_state   = ARB_BUSY;
          w_nxt_mem_req = 1'b1;
          w_nxt_gnt     = w_gnt_port;
          if (w_gnt_port == GNT_D) begin
            w_nxt_mem_we    = i_d_we;
            w_nxt_mem_addr  = i_d_addr;
            w_nxt_mem_wdata = i_d_wdata;
            if (!i_if_req) begin
              w_nxt_dwin_cnt = '0;
            end else if (r_dwin_cnt != CNT_W'(MAX_DWIN)) begin
              w_nxt_dwin_cnt = r_dwin_cnt + CNT_W'(1);
            end
          end else begin
            w_nxt_mem_we    = 1'b0;
            w_nxt_mem_addr  = i_if_addr;
            w_nxt_mem_wdata = '0;
            w_nxt_dwin_cnt  = '0;
          end
        end
      end
      ARB_BUSY: begin
        w_nxt_mem_req = 1'b1;
        if (i_mem_ready) begin
          w_nxt_state   = ARB_RESP;
          w_nxt_mem_req = 1'b0;
          if (r_gnt == GNT_D) begin
            w_nxt_d_ack = 1'b1;
            if (!r_mem_we) w_nxt_d_rdata = i_mem_rdata;
          end else begin
            w_nxt_if_ack   = 1'b1;
            w_nxt_if_rdata = i_mem_rdata;
          end
        end
      end
      ARB_RESP: w_nxt_state = ARB_IDLE;
      default:  w_nxt_state = ARB_IDLE;
    endcase
  end

  assign o_if_rdata  = r_if_rdata;
  assign o_if_ack    = r_if_ack;
  assign o_d_rdata   = r_d_rdata;
  assign o_d_ack     = r_d_ack;
  assign o_mem_req   = r_mem_req;
  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a transaction-level reference model
// checked every cycle, plus literal expectations per scenario.
module tb_mem_arbiter;

  localparam int unsigned MAXW = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [31:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;
  logic [31:0] o_if_rdata, o_d_rdata, o_mem_addr, o_mem_wdata;
  logic        o_if_ack, o_d_ack, o_mem_req, o_mem_we;

  int tests = 0;
  int fails = 0;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_DWIN(MAXW)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_if_req    (if_req),
    .i_if_addr   (if_addr),
    .o_if_rdata  (o_if_rdata),
    .o_if_ack    (o_if_ack),
    .i_d_req     (d_req),
    .i_d_we      (d_we),
    .i_d_addr    (d_addr),
    .i_d_wdata   (d_wdata),
    .o_d_rdata   (o_d_rdata),
    .o_d_ack     (o_d_ack),
    .o_mem_req   (o_mem_req),
    .o_mem_we    (o_mem_we),
    .o_mem_addr  (o_mem_addr),
    .o_mem_wdata (o_mem_wdata),
    .i_mem_rdata (mem_rdata),
    .i_mem_ready (mem_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h at %0t", nm, got, exp, $time);
    end
  endtask

  // Reference model: one outstanding access record; the fetch port's
  // patience is the number of data grants it has sat through.
  bit          m_valid = 0;
  bit          m_rst_now = 0;
  bit          m_active = 0;   // access handed to memory, waiting for ready
  bit          m_cooldown = 0; // ack cycle, nobody may be granted
  bit          m_is_d = 0;
  int          m_patience = 0;
  logic        m_mreq = 0, m_we = 0, m_if_ack = 0, m_d_ack = 0;
  logic [31:0] m_addr = '0, m_wdata = '0, m_if_rdata = '0, m_d_rdata = '0;

  always @(posedge clk) begin
    m_if_ack  = 1'b0;
    m_d_ack   = 1'b0;
    m_rst_now = !rst;
    if (!rst) begin
      m_valid = 1; m_active = 0; m_cooldown = 0; m_patience = 0;
      m_mreq = 0; m_we = 0; m_addr = '0; m_wdata = '0;
      m_if_rdata = '0; m_d_rdata = '0;
    end else if (m_cooldown) begin
      m_cooldown = 0;
    end else if (m_active) begin
      if (mem_ready) begin
        m_active = 0; m_cooldown = 1; m_mreq = 0;
        if (m_is_d) begin
          m_d_ack = 1;
          if (!m_we) m_d_rdata = mem_rdata;
        end else begin
          m_if_ack = 1;
          m_if_rdata = mem_rdata;
        end
      end
    end else if (d_req && (!if_req || m_patience < int'(MAXW))) begin
      m_is_d = 1; m_active = 1; m_mreq = 1;
      m_we = d_we; m_addr = d_addr; m_wdata = d_wdata;
      m_patience = if_req ? ((m_patience + 1 > int'(MAXW)) ? int'(MAXW) : m_patience + 1) : 0;
    end else if (if_req) begin
      m_is_d = 0; m_active = 1; m_mreq = 1;
      m_we = 0; m_addr = if_addr;
      m_patience = 0;
    end
  end

  // Per-cycle comparison against the model, sampled mid-cycle.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("mem_req", 32'(o_mem_req), 32'(m_mreq));
      chk("if_ack", 32'(o_if_ack), 32'(m_if_ack));
      chk("d_ack", 32'(o_d_ack), 32'(m_d_ack));
      chk("if_rdata", o_if_rdata, m_if_rdata);
      chk("d_rdata", o_d_rdata, m_d_rdata);
      if (m_mreq || m_rst_now) begin
        chk("mem_we", 32'(o_mem_we), 32'(m_we));
        chk("mem_addr", o_mem_addr, m_addr);
      end
      if ((m_mreq && m_we) || m_rst_now) chk("mem_wdata", o_mem_wdata, m_wdata);
    end
  end

  // One access on one port; memory answers k cycles after mem_req rises.
  task automatic do_access(input string nm, input bit is_d, input bit we,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] rdata, input int k,
                           input logic [31:0] exp_rd, input int exp_lat);
    int lat;
    int busy_n;
    bit acked;
    lat = 0; busy_n = 0; acked = 0;
    if (is_d) begin d_req = 1; d_we = we; d_addr = addr; d_wdata = wdata; end
    else begin if_req = 1; if_addr = addr; end
    @(negedge clk); lat = 1;
    chk({nm, "_mreq_up"}, 32'(o_mem_req), 32'd1);
    repeat (k) begin
      busy_n += int'(o_mem_req);
      @(negedge clk); lat++;
    end
    busy_n += int'(o_mem_req);
    mem_ready = 1; mem_rdata = rdata;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); lat++;
      mem_ready = 0;
      acked = is_d ? o_d_ack : o_if_ack;
      if (acked) break;
    end
    chk({nm, "_acked"}, 32'(acked), 32'd1);
    chk({nm, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({nm, "_busy_cycles"}, 32'(busy_n), 32'(k + 1));
    chk({nm, "_other_ack"}, 32'(is_d ? o_if_ack : o_d_ack), 32'd0);
    chk({nm, "_rdata"}, is_d ? o_d_rdata : o_if_rdata, exp_rd);
    if (is_d) d_req = 0; else if_req = 0;
    @(negedge clk);
  endtask

  initial begin
    string exp_order;
    logic [7:0] got_order [10];
    int n;
    int cyc;

    repeat (2) @(negedge clk);
    rst = 1;
    chk("reset_d_rdata", o_d_rdata, 32'h0);
    chk("reset_mem_req", 32'(o_mem_req), 32'd0);
    @(negedge clk);

    do_access("load", 1, 0, 32'h100, 32'h0, 32'hDEADBEEF, 0, 32'hDEADBEEF, 2);
    do_access("store", 1, 1, 32'h104, 32'h12345678, 32'hBAD0BAD0, 3, 32'hDEADBEEF, 5);
    do_access("fetch", 0, 0, 32'h4, 32'h0, 32'h8C220000, 0, 32'h8C220000, 2);

    // Both ports continuously requesting; memory answers immediately.
    exp_order = "DDDDIDDDDI";
    if_req = 1; if_addr = 32'h40; d_req = 1; d_we = 0; d_addr = 32'h200;
    n = 0; cyc = 0;
    while (n < 10 && cyc < 100) begin
      @(negedge clk); cyc++;
      mem_ready = o_mem_req;
      mem_rdata = 32'h1000 + 32'(cyc);
      if (o_d_ack) begin got_order[n] = "D"; n++; end
      else if (o_if_ack) begin got_order[n] = "I"; n++; end
    end
    if_req = 0; d_req = 0; mem_ready = 0;
    chk("contention_grants", 32'(n), 32'd10);
    for (int i = 0; i < 10; i++)
      if (i < n) chk($sformatf("contention_order%0d", i), 32'(got_order[i]), 32'(exp_order[i]));
    @(negedge clk);

    // Stray ready while idle.
    mem_ready = 1; mem_rdata = 32'hFFFFFFFF;
    repeat (3) begin
      @(negedge clk);
      chk("stray_mem_req", 32'(o_mem_req), 32'd0);
      chk("stray_ack", 32'({o_if_ack, o_d_ack}), 32'd0);
    end
    mem_ready = 0;
    do_access("after_stray", 0, 0, 32'h10, 32'h0, 32'h00000020, 0, 32'h00000020, 2);

    // Reset while an access is in BUSY.
    d_req = 1; d_we = 0; d_addr = 32'h300;
    @(negedge clk);
    chk("rstbusy_mem_req", 32'(o_mem_req), 32'd1);
    rst = 0; d_req = 0;
    @(negedge clk);
    chk("rstbusy_mem_req_low", 32'(o_mem_req), 32'd0);
    chk("rstbusy_mem_addr", o_mem_addr, 32'h0);
    chk("rstbusy_d_rdata", o_d_rdata, 32'h0);
    chk("rstbusy_if_rdata", o_if_rdata, 32'h0);
    rst = 1; mem_ready = 1; mem_rdata = 32'h0000FFFF;
    @(negedge clk);
    mem_ready = 0;
    chk("rstbusy_no_ack1", 32'({o_if_ack, o_d_ack}), 32'd0);
    @(negedge clk);
    chk("rstbusy_no_ack2", 32'({o_if_ack, o_d_ack}), 32'd0);
    chk("rstbusy_d_rdata_kept", o_d_rdata, 32'h0);
    do_access("after_rst", 0, 0, 32'h8, 32'h0, 32'h24420001, 1, 32'h24420001, 3);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
